lvds_check_result: RTL and testbench

- Downstream consumer of the 4-bit per-channel LVDS ready vector produced by the LVDS input-status stage.
- Runs one commanded check: settle, then sample ready_channel over a fixed number of measurement windows paced by the 1 MHz tick.
- Decides per-channel pass/fail against a threshold and reports one status byte to the control/telemetry side over a valid/ready handshake.

---
 rtl/lvds_check_pkg.sv | 29 ++
 rtl/lvds_tick_sync.sv | 32 +++
 rtl/lvds_check_result.sv | 181 ++++++++++++++++++
 tb/tb_lvds_check_result.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/lvds_check_pkg.sv
// Shared types and status-byte layout for the LVDS ready-check block.
// The status byte is {fault, run_cnt[2:0], ch_ok[3:0]}.
package lvds_check_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETTLE   = 3'd1,
        MEASURE  = 3'd2,
        EVALUATE = 3'd3,
        REPORT   = 3'd4
    } state_t;

    localparam int N_CH      = 4;
    localparam int FAULT_BIT = 7;
    localparam int RUN_LSB   = 4;
    localparam int OK_LSB    = 0;

    function automatic logic [7:0] pack_stat(input logic       fault,
                                             input logic [2:0] run,
                                             input logic [3:0] ok);
        logic [7:0] s;
        s                = 8'h00;
        s[FAULT_BIT]     = fault;
        s[RUN_LSB +: 3]  = run;
        s[OK_LSB +: 4]   = ok;
        return s;
    endfunction

endpackage

// File: rtl/lvds_tick_sync.sv
// Brings the free-running 1 MHz clock into the system domain as data and
// emits a registered one-cycle tick 2-3 cycles after each of its rising edges.
module lvds_tick_sync (
    input  logic clk,
    input  logic rst,
    input  logic slow_clk,
    output logic tick
);

    logic meta_r;
    logic sync_r;
    logic prev_r;
    logic tick_r;

    // Two-flop synchroniser followed by a registered rising-edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            prev_r <= 1'b0;
            tick_r <= 1'b0;
        end else begin
            meta_r <= slow_clk;
            sync_r <= meta_r;
            prev_r <= sync_r;
            tick_r <= sync_r & ~prev_r;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/lvds_check_result.sv
// Runs one commanded LVDS ready check: settle, count ready windows per channel,
// judge against PASS_MIN and hand one status byte over a valid/ready handshake.
module lvds_check_result
    import lvds_check_pkg::*;
#(
    parameter int N_CH         = lvds_check_pkg::N_CH,
    parameter int WIN_TICKS    = 16,
    parameter int N_WINDOWS    = 16,
    parameter int PASS_MIN     = 14,
    parameter int SETTLE_TICKS = 32
) (
    input  logic            clk_100Mz,
    input  logic            rst,
    input  logic            clk_1Mz,
    input  logic            start,
    input  logic [N_CH-1:0] ready_channel,
    output logic            busy,
    output logic            done,
    output logic [N_CH-1:0] ch_ok,
    output logic            fault,
    output logic            stat_valid,
    input  logic            stat_ready,
    output logic [7:0]      stat_data
);

    localparam int TMAX = (SETTLE_TICKS > WIN_TICKS) ? SETTLE_TICKS : WIN_TICKS;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int WW   = (N_WINDOWS > 1) ? $clog2(N_WINDOWS) : 1;
    localparam int PW   = $clog2(N_WINDOWS + 1);

    if (PASS_MIN < 1 || PASS_MIN > N_WINDOWS || N_CH != 4) begin : g_param_check
        $fatal(1, "lvds_check_result: PASS_MIN must be 1..N_WINDOWS and N_CH must be 4");
    end

    state_t            state_r;
    state_t            next_state_s;
    logic              tick_s;
    logic [TW-1:0]     tick_cnt_r;
    logic [WW-1:0]     win_cnt_r;
    logic [PW-1:0]     pass_cnt_r [N_CH];
    logic [2:0]        run_cnt_r;
    logic              busy_r;
    logic              done_r;
    logic [N_CH-1:0]   ch_ok_r;
    logic              fault_r;
    logic              stat_valid_r;
    logic [7:0]        stat_data_r;
    logic [N_CH-1:0]   ok_next_s;
    logic              fault_next_s;
    logic              settle_end_s;
    logic              win_end_s;
    logic              last_win_s;
    logic              handshake_s;

    lvds_tick_sync u_tick_sync (
        .clk      (clk_100Mz),
        .rst      (rst),
        .slow_clk (clk_1Mz),
        .tick     (tick_s)
    );

    assign settle_end_s = tick_s && (tick_cnt_r == TW'(SETTLE_TICKS - 1));
    assign win_end_s    = tick_s && (tick_cnt_r == TW'(WIN_TICKS - 1));
    assign last_win_s   = (win_cnt_r == WW'(N_WINDOWS - 1));
    assign handshake_s  = stat_valid_r && stat_ready;

    // Per-channel verdict from the accumulated window counts
    always_comb begin
        ok_next_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            ok_next_s[i] = (pass_cnt_r[i] >= PW'(PASS_MIN));
        end
        fault_next_s = ~&ok_next_s;
    end

    // State register
    always_ff @(posedge clk_100Mz or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode; start is only honoured from IDLE
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) next_state_s = SETTLE;
                else       next_state_s = IDLE;
            end
            SETTLE: begin
                if (settle_end_s) next_state_s = MEASURE;
                else              next_state_s = SETTLE;
            end
            MEASURE: begin
                if (win_end_s && last_win_s) next_state_s = EVALUATE;
                else                         next_state_s = MEASURE;
            end
            EVALUATE: next_state_s = REPORT;
            REPORT: begin
                if (handshake_s) next_state_s = IDLE;
                else             next_state_s = REPORT;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Counters, verdict registers and the report handshake
    always_ff @(posedge clk_100Mz or posedge rst) begin
        if (rst) begin
            tick_cnt_r   <= '0;
            win_cnt_r    <= '0;
            for (int i = 0; i < N_CH; i++) pass_cnt_r[i] <= '0;
            run_cnt_r    <= 3'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            ch_ok_r      <= {N_CH{1'b0}};
            fault_r      <= 1'b0;
            stat_valid_r <= 1'b0;
            stat_data_r  <= 8'h00;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        tick_cnt_r <= '0;
                        win_cnt_r  <= '0;
                        for (int i = 0; i < N_CH; i++) pass_cnt_r[i] <= '0;
                        busy_r     <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (settle_end_s)  tick_cnt_r <= '0;
                    else if (tick_s)   tick_cnt_r <= tick_cnt_r + TW'(1);
                end
                MEASURE: begin
                    // Only the window-closing tick samples ready_channel
                    if (win_end_s) begin
                        tick_cnt_r <= '0;
                        for (int i = 0; i < N_CH; i++) begin
                            if (ready_channel[i] && (pass_cnt_r[i] != PW'(N_WINDOWS))) begin
                                pass_cnt_r[i] <= pass_cnt_r[i] + PW'(1);
                            end
                        end
                        if (!last_win_s) win_cnt_r <= win_cnt_r + WW'(1);
                    end else if (tick_s) begin
                        tick_cnt_r <= tick_cnt_r + TW'(1);
                    end
                end
                EVALUATE: begin
                    ch_ok_r      <= ok_next_s;
                    fault_r      <= fault_next_s;
                    stat_data_r  <= pack_stat(fault_next_s, run_cnt_r, ok_next_s[3:0]);
                    stat_valid_r <= 1'b1;
                end
                REPORT: begin
                    if (handshake_s) begin
                        stat_valid_r <= 1'b0;
                        run_cnt_r    <= run_cnt_r + 3'd1;
                        done_r       <= 1'b1;
                        busy_r       <= 1'b0;
                    end
                end
                default: begin
                    busy_r       <= 1'b0;
                    stat_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign ch_ok      = ch_ok_r;
    assign fault      = fault_r;
    assign stat_valid = stat_valid_r;
    assign stat_data  = stat_data_r;

endmodule

// File: tb/tb_lvds_check_result.sv
// Directed bench for lvds_check_result; the 1 MHz input is sped up to one
// rising edge every 8 system cycles so a full run takes about 2300 cycles.
module tb_lvds_check_result;

    localparam int LIMIT = 6000;

    logic       clk_100Mz = 1'b0;
    logic       clk_1Mz   = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] ready_channel;
    logic       busy;
    logic       done;
    logic [3:0] ch_ok;
    logic       fault;
    logic       stat_valid;
    logic       stat_ready;
    logic [7:0] stat_data;

    int errors   = 0;
    int checks   = 0;
    int edge_cnt = 0;
    int base     = 0;
    bit slow_en  = 1'b1;

    lvds_check_result dut (
        .clk_100Mz     (clk_100Mz),
        .rst           (rst),
        .clk_1Mz       (clk_1Mz),
        .start         (start),
        .ready_channel (ready_channel),
        .busy          (busy),
        .done          (done),
        .ch_ok         (ch_ok),
        .fault         (fault),
        .stat_valid    (stat_valid),
        .stat_ready    (stat_ready),
        .stat_data     (stat_data)
    );

    always #5 clk_100Mz = ~clk_100Mz;

    initial begin
        #3;
        forever begin
            #40;
            clk_1Mz = slow_en ? ~clk_1Mz : 1'b0;
        end
    end

    always @(posedge clk_1Mz) edge_cnt = edge_cnt + 1;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_edges(input int target);
        int n = 0;
        while (edge_cnt < target && n < LIMIT) begin
            @(negedge clk_100Mz);
            n++;
        end
        chk("edge_wait", 8'(edge_cnt >= target), 8'h01);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (stat_valid !== 1'b1 && n < LIMIT) begin
            @(negedge clk_100Mz);
            n++;
        end
        chk({tag, "_valid"}, {7'h00, stat_valid}, 8'h01);
    endtask

    task automatic pulse_start();
        base  = edge_cnt;
        start = 1'b1;
        @(negedge clk_100Mz);
        start = 1'b0;
    endtask

    task automatic finish_run(input string tag, input logic [7:0] exp, input bit start_on_report);
        wait_valid(tag);
        chk({tag, "_data"},  stat_data, exp);
        chk({tag, "_ok"},    {4'h0, ch_ok}, {4'h0, exp[3:0]});
        chk({tag, "_fault"}, {7'h00, fault}, {7'h00, exp[7]});
        chk({tag, "_busy_report"}, {7'h00, busy}, 8'h01);
        start = start_on_report;
        @(negedge clk_100Mz);
        start = 1'b0;
        chk({tag, "_done"},       {7'h00, done},       8'h01);
        chk({tag, "_busy_after"}, {7'h00, busy},       8'h00);
        chk({tag, "_valid_drop"}, {7'h00, stat_valid}, 8'h00);
        @(negedge clk_100Mz);
        chk({tag, "_done_once"},  {7'h00, done},       8'h00);
    endtask

    // ch0 follows pat per window; glitch3 drops ch3 mid-window, never at a sample
    task automatic pattern_run(input logic [15:0] pat, input bit glitch3);
        ready_channel = {3'b111, pat[0]};
        pulse_start();
        for (int w = 0; w < 16; w++) begin
            wait_edges(base + 40 + 16 * w);
            ready_channel[0] = pat[w];
            ready_channel[3] = ~glitch3;
            wait_edges(base + 44 + 16 * w);
            ready_channel[3] = 1'b1;
        end
    endtask

    initial begin
        int n;
        int bad;
        int busy_low;
        int dones;

        rst           = 1'b0;
        start         = 1'b0;
        stat_ready    = 1'b1;
        ready_channel = 4'hF;
        #1 rst = 1'b1;
        @(negedge clk_100Mz);
        @(negedge clk_100Mz);
        chk("rst_busy",  {7'h00, busy},       8'h00);
        chk("rst_done",  {7'h00, done},       8'h00);
        chk("rst_ok",    {4'h0, ch_ok},       8'h00);
        chk("rst_fault", {7'h00, fault},      8'h00);
        chk("rst_valid", {7'h00, stat_valid}, 8'h00);
        chk("rst_data",  stat_data,           8'h00);
        rst = 1'b0;
        @(negedge clk_100Mz);

        // All channels ready
        ready_channel = 4'hF;
        pulse_start();
        chk("t1_busy_start", {7'h00, busy}, 8'h01);
        finish_run("t1", 8'h0F, 1'b0);

        // ch2 never ready; run counter restarts from reset
        rst = 1'b1;
        @(negedge clk_100Mz);
        rst = 1'b0;
        @(negedge clk_100Mz);
        ready_channel = 4'hB;
        pulse_start();
        finish_run("t2a", 8'h8B, 1'b0);
        pulse_start();
        finish_run("t2b", 8'h9B, 1'b0);

        // PASS_MIN boundary on ch0: 13 windows fail, 14 pass
        pattern_run(16'hBDF7, 1'b0);
        finish_run("t3_13win", 8'hAE, 1'b0);
        pattern_run(16'hBDFF, 1'b1);
        finish_run("t3_14win", 8'h3F, 1'b0);

        // Consumer back-pressure in REPORT
        ready_channel = 4'hF;
        stat_ready    = 1'b0;
        pulse_start();
        wait_valid("t4");
        chk("t4_data", stat_data, 8'h4F);
        bad = 0;
        repeat (100) begin
            @(negedge clk_100Mz);
            if (stat_valid !== 1'b1 || stat_data !== 8'h4F || done !== 1'b0) bad++;
        end
        chk("t4_hold", 8'(bad), 8'h00);
        stat_ready = 1'b1;
        @(negedge clk_100Mz);
        chk("t4_done",  {7'h00, done},       8'h01);
        chk("t4_valid", {7'h00, stat_valid}, 8'h00);
        @(negedge clk_100Mz);
        chk("t4_done_once", {7'h00, done}, 8'h00);

        // start during SETTLE, MEASURE and alongside the handshake is ignored
        pulse_start();
        wait_edges(base + 10);
        start = 1'b1;
        @(negedge clk_100Mz);
        start = 1'b0;
        wait_edges(base + 100);
        start = 1'b1;
        @(negedge clk_100Mz);
        start = 1'b0;
        wait_valid("t5_pre");
        n = edge_cnt - base;
        chk("t5_latency", 8'((n >= 287) && (n <= 288)), 8'h01);
        finish_run("t5", 8'h5F, 1'b1);
        repeat (20) @(negedge clk_100Mz);
        chk("t5_no_restart", {7'h00, busy}, 8'h00);

        // Reset mid-MEASURE clears everything asynchronously
        pulse_start();
        wait_edges(base + 100);
        rst = 1'b1;
        #1;
        chk("t6_busy",  {7'h00, busy},       8'h00);
        chk("t6_valid", {7'h00, stat_valid}, 8'h00);
        chk("t6_data",  stat_data,           8'h00);
        chk("t6_ok",    {4'h0, ch_ok},       8'h00);
        chk("t6_fault", {7'h00, fault},      8'h00);
        @(negedge clk_100Mz);
        rst = 1'b0;
        @(negedge clk_100Mz);
        pulse_start();
        finish_run("t6_rerun", 8'h0F, 1'b0);

        // Stopped 1 MHz clock: run never completes
        slow_en = 1'b0;
        repeat (20) @(negedge clk_100Mz);
        pulse_start();
        busy_low = 0;
        dones    = 0;
        repeat (500) begin
            @(negedge clk_100Mz);
            if (busy !== 1'b1) busy_low++;
            if (done !== 1'b0) dones++;
        end
        chk("t6_stuck_busy", 8'(busy_low), 8'h00);
        chk("t6_stuck_done", 8'(dones),    8'h00);
        rst = 1'b1;
        @(negedge clk_100Mz);
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
